ps2_cmd_arbiter: RTL and testbench
==================================

Name: ps2_cmd_arbiter

Overview:
- Shares the PS/2 byte transmitter and receiver between two requesters: the mouse master state machine (setup traffic, streamed packets) and a processor-side host command channel (e.g. set sample rate F3+arg, set resolution E8+arg).
- Sits between the master state machine and the transmitter/receiver pair.
- Sequences each host command: command byte, mouse FA ack, optional argument byte, second FA ack.
- Handles FE resend with retry limit, and ack timeout.

Parameters:
- ACK_TIMEOUT, 2000000, cycles to wait for byte-sent or ack before aborting a host transaction (20 ms at 100 MHz).
- RETRY_MAX, 2, number of resends of the current byte allowed on FE response.
- WINDOW_CYCLES, 50000, cycles after a packet-complete pulse during which a host command may be granted.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- SM_SEND_BYTE  in  1  master SM send request pulse
- SM_BYTE_TO_SEND  in  8  master SM byte
- SM_BYTE_SENT  out  1  byte-sent pulse forwarded to master SM
- SM_READ_ENABLE  in  1  master SM receiver consume pulse
- SM_BYTE_READY  out  1  gated byte-ready to master SM
- SM_PKT_DONE  in  1  master SM packet-complete/interrupt pulse
- TX_SEND_BYTE  out  1  send pulse to transmitter
- TX_BYTE  out  8  byte to transmitter
- TX_BYTE_SENT  in  1  transmitter done pulse
- RX_BYTE_READ  in  8  received byte
- RX_ERROR_CODE  in  2  receiver error, 00 = good
- RX_BYTE_READY  in  1  receiver byte valid (level)
- RX_READ_ENABLE  out  1  consume pulse to receiver
- HOST_REQ  in  1  command request, sampled in IDLE only
- HOST_CMD  in  8  command byte
- HOST_HAS_ARG  in  1  command carries argument byte
- HOST_ARG  in  8  argument byte
- HOST_BUSY  out  1  transaction accepted and in progress
- HOST_DONE  out  1  one-cycle pulse, success
- HOST_ERR  out  1  one-cycle pulse, failure (timeout, bad ack, retries exhausted)

Behaviour:
- Reset values: all outputs 0; state IDLE; link_up=0; window/timeout/retry counters 0. RESET mid-transaction aborts immediately without HOST_DONE or HOST_ERR.
- link_up is set on the first SM_PKT_DONE and stays set until reset. window_ctr loads WINDOW_CYCLES on each SM_PKT_DONE and decrements to 0.
- Master SM path, when no host transaction is active:
  - TX_SEND_BYTE=SM_SEND_BYTE and TX_BYTE=SM_BYTE_TO_SEND, registered, 1-cycle latency.
  - SM_BYTE_SENT=TX_BYTE_SENT, SM_BYTE_READY=RX_BYTE_READY, combinational.
  - RX_READ_ENABLE = SM_READ_ENABLE OR own consume pulse.
- Grant: in IDLE, HOST_REQ && link_up && window_ctr!=0 && !SM_SEND_BYTE -> latch CMD, HAS_ARG, ARG; HOST_BUSY=1; go to H_SEND. A request outside the window waits in IDLE; the requester holds HOST_REQ.
- During any H_* state:
  - SM_BYTE_READY and SM_BYTE_SENT are forced 0.
  - SM_SEND_BYTE is ignored.
  - Received bytes go to the arbiter only.
- State machine:
  - H_SEND: 1-cycle TX_SEND_BYTE with current byte (CMD, or ARG when phase=1); clear timeout counter; -> H_WAIT_SENT.
  - H_WAIT_SENT: TX_BYTE_SENT -> H_WAIT_ACK.
  - H_WAIT_ACK: on RX_BYTE_READY, pulse RX_READ_ENABLE for 1 cycle, then evaluate:
    - FA with error 00: if phase=0 and HAS_ARG, set phase=1, retry=0, -> H_SEND; otherwise -> H_DONE.
    - FE with error 00 and retry<RETRY_MAX: retry+1, -> H_SEND with the same byte.
    - Anything else, including FE when retry==RETRY_MAX or a nonzero error code: -> H_ERR.
  - Timeout: reaching ACK_TIMEOUT in H_WAIT_SENT or H_WAIT_ACK -> H_ERR.
  - H_DONE / H_ERR: pulse HOST_DONE or HOST_ERR for 1 cycle; HOST_BUSY=0 in the same cycle; clear phase and retry; -> IDLE.
- Timeout counter: 24 bits, saturating; does not wrap.
- SM_PKT_DONE arriving during a transaction only reloads window_ctr.

Decomposition:
- Shared package ps2_pkg:
  - State encoding typedef.
  - Constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ERR_NONE=2'b00.
- Sub-module ps2_timeout_ctr: parameterised saturating counter with clear/enable/expired.

Test Plan:
- Passthrough: before link_up, SM_SEND_BYTE with FF -> TX_SEND_BYTE/TX_BYTE=FF one cycle later; TX_BYTE_SENT reaches SM_BYTE_SENT in the same cycle.
- Host with arg: after SM_PKT_DONE, HOST_REQ CMD=F3 ARG=28 HAS_ARG=1; mouse returns FA, FA -> TX bytes F3 then 28; two RX_READ_ENABLE pulses; HOST_DONE once; SM_BYTE_READY stays 0 throughout.
- Resend: CMD=E8 no arg; RX FE, FE, FA with RETRY_MAX=2 -> E8 sent 3 times, HOST_DONE. RX FE ×3 -> HOST_ERR after the third.
- Timeout: ACK_TIMEOUT=100; no RX after byte sent -> HOST_ERR exactly 100 cycles into H_WAIT_ACK; HOST_BUSY low.
- Gating: HOST_REQ with link_up=0, or window expired -> no TX activity, HOST_BUSY=0; the next SM_PKT_DONE grants within 1 cycle.
- Reset mid-transaction: assert RESET in H_WAIT_ACK -> all outputs 0 immediately; no DONE/ERR pulse; link_up=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 command arbiter: FSM encoding and
// protocol byte constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    H_SEND,
    H_WAIT_SENT,
    H_WAIT_ACK,
    H_DONE,
    H_ERR
  } arb_state_t;

  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [1:0] PS2_ERR_NONE = 2'b00;

endpackage

// File: rtl/ps2_timeout_ctr.sv
// Saturating cycle counter. Expired flags the enabled cycle on which the
// count reaches LIMIT, so the owner reacts exactly LIMIT cycles after clear.
module ps2_timeout_ctr #(
  parameter int WIDTH = 24,
  parameter int LIMIT = 2000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && !clr && (count >= WIDTH'(LIMIT - 1));

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// Shares the PS/2 transmitter/receiver between the mouse master SM and a
// host command channel that runs command/ack/argument/ack transactions.
module ps2_cmd_arbiter
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT   = 2000000,
  parameter int RETRY_MAX     = 2,
  parameter int WINDOW_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SM_SEND_BYTE,
  input  logic [7:0] SM_BYTE_TO_SEND,
  output logic       SM_BYTE_SENT,
  input  logic       SM_READ_ENABLE,
  output logic       SM_BYTE_READY,
  input  logic       SM_PKT_DONE,
  output logic       TX_SEND_BYTE,
  output logic [7:0] TX_BYTE,
  input  logic       TX_BYTE_SENT,
  input  logic [7:0] RX_BYTE_READ,
  input  logic [1:0] RX_ERROR_CODE,
  input  logic       RX_BYTE_READY,
  output logic       RX_READ_ENABLE,
  input  logic       HOST_REQ,
  input  logic [7:0] HOST_CMD,
  input  logic       HOST_HAS_ARG,
  input  logic [7:0] HOST_ARG,
  output logic       HOST_BUSY,
  output logic       HOST_DONE,
  output logic       HOST_ERR
);

  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int RW = $clog2(RETRY_MAX + 2);

  arb_state_t    state;
  logic          link_up;
  logic [WW-1:0] window_ctr;
  logic [7:0]    cmd_q;
  logic [7:0]    arg_q;
  logic          has_arg_q;
  logic          phase;
  logic [RW-1:0] retry;
  logic          tx_send_q;
  logic [7:0]    tx_byte_q;
  logic          rx_rd_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic       host_active;
  logic       grant;
  logic       rx_good;
  logic [7:0] cur_byte;
  logic       to_clr;
  logic       to_en;
  logic       to_expired;

  assign host_active = (state != IDLE);
  assign grant       = (state == IDLE) && HOST_REQ && link_up &&
                       (window_ctr != '0) && !SM_SEND_BYTE;
  assign rx_good     = (RX_ERROR_CODE == PS2_ERR_NONE);
  assign cur_byte    = phase ? arg_q : cmd_q;

  // Each wait (byte-sent, then ack) gets its own full timeout budget.
  assign to_clr = (state == H_SEND) || ((state == H_WAIT_SENT) && TX_BYTE_SENT);
  assign to_en  = (state == H_WAIT_SENT) || (state == H_WAIT_ACK);

  ps2_timeout_ctr #(
    .WIDTH (24),
    .LIMIT (ACK_TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  assign TX_SEND_BYTE   = tx_send_q;
  assign TX_BYTE        = tx_byte_q;
  assign SM_BYTE_SENT   = host_active ? 1'b0 : TX_BYTE_SENT;
  assign SM_BYTE_READY  = host_active ? 1'b0 : RX_BYTE_READY;
  assign RX_READ_ENABLE = (SM_READ_ENABLE && !host_active) || rx_rd_q;
  assign HOST_BUSY      = busy_q;
  assign HOST_DONE      = done_q;
  assign HOST_ERR       = err_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      link_up    <= 1'b0;
      window_ctr <= '0;
    end else if (SM_PKT_DONE) begin
      link_up    <= 1'b1;
      window_ctr <= WW'(WINDOW_CYCLES);
    end else if (window_ctr != '0) begin
      window_ctr <= window_ctr - 1'b1;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // blocking here would let later statements see already-updated state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cmd_q     <= '0;
      arg_q     <= '0;
      has_arg_q <= 1'b0;
      phase     <= 1'b0;
      retry     <= '0;
      tx_send_q <= 1'b0;
      tx_byte_q <= '0;
      rx_rd_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      rx_rd_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        IDLE: begin
          tx_send_q <= SM_SEND_BYTE;
          tx_byte_q <= SM_BYTE_TO_SEND;
          if (grant) begin
            cmd_q     <= HOST_CMD;
            arg_q     <= HOST_ARG;
            has_arg_q <= HOST_HAS_ARG;
            phase     <= 1'b0;
            retry     <= '0;
            busy_q    <= 1'b1;
            tx_send_q <= 1'b1;
            tx_byte_q <= HOST_CMD;
            state     <= H_SEND;
          end
        end
        H_SEND: state <= H_WAIT_SENT;
        H_WAIT_SENT: begin
          if (TX_BYTE_SENT) begin
            state <= H_WAIT_ACK;
          end else if (to_expired) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= H_ERR;
          end
        end
        H_WAIT_ACK: begin
          if (RX_BYTE_READY) begin
            rx_rd_q <= 1'b1;
            if (rx_good && (RX_BYTE_READ == PS2_ACK)) begin
              if (!phase && has_arg_q) begin
                phase     <= 1'b1;
                retry     <= '0;
                tx_send_q <= 1'b1;
                tx_byte_q <= arg_q;
                state     <= H_SEND;
              end else begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                state  <= H_DONE;
              end
            end else if (rx_good && (RX_BYTE_READ == PS2_RESEND) &&
                         (retry < RW'(RETRY_MAX))) begin
              retry     <= retry + 1'b1;
              tx_send_q <= 1'b1;
              tx_byte_q <= cur_byte;
              state     <= H_SEND;
            end else begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= H_ERR;
            end
          end else if (to_expired) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= H_ERR;
          end
        end
        H_DONE, H_ERR: begin
          phase <= 1'b0;
          retry <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Directed bench for ps2_cmd_arbiter: passthrough vector table plus
// hand-written host transaction, resend, timeout, gating and reset sequences.
module tb_ps2_cmd_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SM_SEND_BYTE = 1'b0;
  logic [7:0] SM_BYTE_TO_SEND = '0;
  logic       SM_BYTE_SENT;
  logic       SM_READ_ENABLE = 1'b0;
  logic       SM_BYTE_READY;
  logic       SM_PKT_DONE = 1'b0;
  logic       TX_SEND_BYTE;
  logic [7:0] TX_BYTE;
  logic       TX_BYTE_SENT = 1'b0;
  logic [7:0] RX_BYTE_READ = '0;
  logic [1:0] RX_ERROR_CODE = '0;
  logic       RX_BYTE_READY = 1'b0;
  logic       RX_READ_ENABLE;
  logic       HOST_REQ = 1'b0;
  logic [7:0] HOST_CMD = '0;
  logic       HOST_HAS_ARG = 1'b0;
  logic [7:0] HOST_ARG = '0;
  logic       HOST_BUSY;
  logic       HOST_DONE;
  logic       HOST_ERR;

  always #5 CLK = ~CLK;

  ps2_cmd_arbiter #(
    .ACK_TIMEOUT   (100),
    .RETRY_MAX     (2),
    .WINDOW_CYCLES (40)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .SM_SEND_BYTE    (SM_SEND_BYTE),
    .SM_BYTE_TO_SEND (SM_BYTE_TO_SEND),
    .SM_BYTE_SENT    (SM_BYTE_SENT),
    .SM_READ_ENABLE  (SM_READ_ENABLE),
    .SM_BYTE_READY   (SM_BYTE_READY),
    .SM_PKT_DONE     (SM_PKT_DONE),
    .TX_SEND_BYTE    (TX_SEND_BYTE),
    .TX_BYTE         (TX_BYTE),
    .TX_BYTE_SENT    (TX_BYTE_SENT),
    .RX_BYTE_READ    (RX_BYTE_READ),
    .RX_ERROR_CODE   (RX_ERROR_CODE),
    .RX_BYTE_READY   (RX_BYTE_READY),
    .RX_READ_ENABLE  (RX_READ_ENABLE),
    .HOST_REQ        (HOST_REQ),
    .HOST_CMD        (HOST_CMD),
    .HOST_HAS_ARG    (HOST_HAS_ARG),
    .HOST_ARG        (HOST_ARG),
    .HOST_BUSY       (HOST_BUSY),
    .HOST_DONE       (HOST_DONE),
    .HOST_ERR        (HOST_ERR)
  );

  int checks = 0;
  int failures = 0;

  // Event counters sampled mid-cycle; tests compare deltas across a sequence.
  int n_tx = 0, n_rd = 0, n_done = 0, n_err = 0, n_leak = 0;
  always @(negedge CLK) begin
    if (TX_SEND_BYTE) n_tx++;
    if (RX_READ_ENABLE) n_rd++;
    if (HOST_DONE) n_done++;
    if (HOST_ERR) n_err++;
    if (HOST_BUSY && (SM_BYTE_READY || SM_BYTE_SENT)) n_leak++;
  end

  typedef struct {
    logic       sm_send;
    logic [7:0] sm_byte;
    logic       tx_sent;
    logic       rx_ready;
    logic       sm_rd;
    logic       exp_sm_sent;
    logic       exp_sm_ready;
    logic       exp_rx_rd;
    logic       exp_tx_send;
    logic [7:0] exp_tx_byte;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pkt_done();
    SM_PKT_DONE = 1'b1;
    tick();
    SM_PKT_DONE = 1'b0;
  endtask

  task automatic host_req(input logic [7:0] cmd, input logic has_arg, input logic [7:0] arg);
    HOST_CMD = cmd;
    HOST_HAS_ARG = has_arg;
    HOST_ARG = arg;
    HOST_REQ = 1'b1;
    for (int i = 0; i < 5 && !HOST_BUSY; i++) tick();
    HOST_REQ = 1'b0;
    check("grant", HOST_BUSY, 1);
  endtask

  // Acts as transmitter and mouse for one byte: capture it, report sent,
  // then return resp through the receiver and wait for the consume pulse.
  task automatic mouse_xfer(input logic [7:0] resp, output logic [7:0] sent);
    int i;
    i = 0;
    while (!TX_SEND_BYTE && i < 50) begin
      tick();
      i++;
    end
    check("tx_send_seen", TX_SEND_BYTE, 1);
    sent = TX_BYTE;
    tick();
    TX_BYTE_SENT = 1'b1;
    #1 check("sm_sent_gated", SM_BYTE_SENT, 0);
    tick();
    TX_BYTE_SENT = 1'b0;
    RX_BYTE_READ = resp;
    RX_ERROR_CODE = 2'b00;
    RX_BYTE_READY = 1'b1;
    i = 0;
    while (!RX_READ_ENABLE && i < 20) begin
      tick();
      i++;
    end
    check("rx_consume", RX_READ_ENABLE, 1);
    RX_BYTE_READY = 1'b0;
  endtask

  task automatic wait_result();
    for (int i = 0; i < 50 && !HOST_DONE && !HOST_ERR; i++) tick();
  endtask

  logic [7:0] b;
  int t0, r0, d0, e0, l0, n;

  initial begin
    vecs[0] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[2] = '{1'b1, 8'hF4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF4};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};

    tick(); tick();
    check("reset_outputs", {TX_SEND_BYTE, TX_BYTE, SM_BYTE_SENT, SM_BYTE_READY,
                            RX_READ_ENABLE, HOST_BUSY, HOST_DONE, HOST_ERR}, 0);
    RESET = 1'b0;
    tick();
    check("post_reset_idle", {TX_SEND_BYTE, HOST_BUSY, HOST_DONE, HOST_ERR}, 0);

    // Master SM passthrough before link_up.
    for (int v = 0; v < 4; v++) begin
      SM_SEND_BYTE    = vecs[v].sm_send;
      SM_BYTE_TO_SEND = vecs[v].sm_byte;
      TX_BYTE_SENT    = vecs[v].tx_sent;
      RX_BYTE_READY   = vecs[v].rx_ready;
      SM_READ_ENABLE  = vecs[v].sm_rd;
      #1;
      check($sformatf("v%0d_sm_byte_sent", v), SM_BYTE_SENT, vecs[v].exp_sm_sent);
      check($sformatf("v%0d_sm_byte_ready", v), SM_BYTE_READY, vecs[v].exp_sm_ready);
      check($sformatf("v%0d_rx_read_enable", v), RX_READ_ENABLE, vecs[v].exp_rx_rd);
      tick();
      SM_SEND_BYTE = 1'b0; TX_BYTE_SENT = 1'b0; RX_BYTE_READY = 1'b0; SM_READ_ENABLE = 1'b0;
      check($sformatf("v%0d_tx_send", v), TX_SEND_BYTE, vecs[v].exp_tx_send);
      check($sformatf("v%0d_tx_byte", v), TX_BYTE, vecs[v].exp_tx_byte);
    end
    tick();

    // Gating on link_up=0, then grant one cycle after the first packet-done.
    t0 = n_tx; r0 = n_rd; d0 = n_done; e0 = n_err; l0 = n_leak;
    HOST_CMD = 8'hF3; HOST_HAS_ARG = 1'b1; HOST_ARG = 8'h28; HOST_REQ = 1'b1;
    repeat (10) tick();
    check("nolink_busy", HOST_BUSY, 0);
    check("nolink_tx", n_tx - t0, 0);
    SM_PKT_DONE = 1'b1;
    tick();
    SM_PKT_DONE = 1'b0;
    check("link_grant_wait", HOST_BUSY, 0);
    tick();
    check("link_grant", HOST_BUSY, 1);
    HOST_REQ = 1'b0;

    // Command with argument: F3, FA, 28, FA.
    mouse_xfer(8'hFA, b);
    check("arg_cmd_byte", b, 8'hF3);
    mouse_xfer(8'hFA, b);
    check("arg_arg_byte", b, 8'h28);
    wait_result();
    check("arg_done", HOST_DONE, 1);
    check("arg_busy_low", HOST_BUSY, 0);
    tick();
    check("arg_done_count", n_done - d0, 1);
    check("arg_err_count", n_err - e0, 0);
    check("arg_tx_count", n_tx - t0, 2);
    check("arg_rd_count", n_rd - r0, 2);
    check("arg_sm_leak", n_leak - l0, 0);

    // Resend: FE, FE, FA succeeds with the same byte three times.
    pkt_done();
    t0 = n_tx; d0 = n_done; e0 = n_err;
    host_req(8'hE8, 1'b0, 8'h00);
    mouse_xfer(8'hFE, b); check("rs1_byte0", b, 8'hE8);
    mouse_xfer(8'hFE, b); check("rs1_byte1", b, 8'hE8);
    mouse_xfer(8'hFA, b); check("rs1_byte2", b, 8'hE8);
    wait_result();
    tick();
    check("rs1_done_count", n_done - d0, 1);
    check("rs1_err_count", n_err - e0, 0);
    check("rs1_tx_count", n_tx - t0, 3);

    // Resend exhausted: FE three times fails after the third.
    pkt_done();
    t0 = n_tx; d0 = n_done; e0 = n_err;
    host_req(8'hE8, 1'b0, 8'h00);
    mouse_xfer(8'hFE, b);
    mouse_xfer(8'hFE, b);
    mouse_xfer(8'hFE, b);
    check("rs2_err_pulse", HOST_ERR, 1);
    check("rs2_busy_low", HOST_BUSY, 0);
    tick();
    check("rs2_done_count", n_done - d0, 0);
    check("rs2_err_count", n_err - e0, 1);
    check("rs2_tx_count", n_tx - t0, 3);

    // Ack timeout: error exactly ACK_TIMEOUT cycles into the ack wait.
    pkt_done();
    e0 = n_err;
    host_req(8'hF4, 1'b0, 8'h00);
    tick();
    TX_BYTE_SENT = 1'b1;
    tick();
    TX_BYTE_SENT = 1'b0;
    n = 0;
    while (!HOST_ERR && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 100);
    check("timeout_busy_low", HOST_BUSY, 0);
    tick();
    check("timeout_err_count", n_err - e0, 1);

    // Window expiry holds the request until the next packet-done.
    pkt_done();
    repeat (45) tick();
    t0 = n_tx;
    HOST_CMD = 8'hF4; HOST_HAS_ARG = 1'b0; HOST_REQ = 1'b1;
    repeat (10) tick();
    check("window_busy", HOST_BUSY, 0);
    check("window_tx", n_tx - t0, 0);
    SM_PKT_DONE = 1'b1;
    tick();
    SM_PKT_DONE = 1'b0;
    tick();
    check("window_grant", HOST_BUSY, 1);
    HOST_REQ = 1'b0;
    mouse_xfer(8'hFA, b);
    check("window_byte", b, 8'hF4);
    wait_result();
    check("window_done", HOST_DONE, 1);
    tick();

    // Reset while waiting for the ack.
    pkt_done();
    d0 = n_done; e0 = n_err;
    host_req(8'hF4, 1'b0, 8'h00);
    tick();
    TX_BYTE_SENT = 1'b1;
    tick();
    TX_BYTE_SENT = 1'b0;
    repeat (3) tick();
    RESET = 1'b1;
    #1;
    check("midreset_outputs", {TX_SEND_BYTE, TX_BYTE, SM_BYTE_SENT, SM_BYTE_READY,
                               RX_READ_ENABLE, HOST_BUSY, HOST_DONE, HOST_ERR}, 0);
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    check("midreset_no_done", n_done - d0, 0);
    check("midreset_no_err", n_err - e0, 0);
    t0 = n_tx;
    HOST_REQ = 1'b1;
    repeat (10) tick();
    check("midreset_link_down", HOST_BUSY, 0);
    check("midreset_no_tx", n_tx - t0, 0);
    HOST_REQ = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
